// File: rtl/trigger_arbiter_if.sv
// trigger_arbiter_if: registered grant channel from the arbiter to the shared stage
interface trigger_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
  logic                 valid;
  logic [NUM_REQ-1:0]   onehot;
  logic [IDX_WIDTH-1:0] idx;
  logic                 ready;
  modport master (output valid, onehot, idx, input ready);
  modport slave (input valid, onehot, idx, output ready);
endinterface

// File: rtl/trigger_arbiter.sv
// trigger_arbiter: per-requester pending-event counters feeding a round-robin,
// one-grant-per-cycle registered valid/ready output
module trigger_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int DELTA_WIDTH = 2,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             delta_valid_i,
  input  logic [NUM_REQ*DELTA_WIDTH-1:0] delta_i,
  output logic [NUM_REQ-1:0]             delta_ready_o,
  trigger_arbiter_if.master              gnt_if,
  output logic [NUM_REQ-1:0]             pending_nz_o,
  output logic                           idle_o
);
  // highest count that can still absorb a maximal delta without wrapping
  localparam logic [CNT_WIDTH-1:0] RDY_LIM = CNT_WIDTH'((2**CNT_WIDTH - 1) - (2**DELTA_WIDTH - 1));
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] pending_q, pending_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [NUM_REQ-1:0]   grant_onehot_q, grant_onehot_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0] rr_q, rr_d;
  logic                 load, found;
  logic [IDX_WIDTH-1:0] sel;
  int                   j;
  assign load = !grant_valid_q || gnt_if.ready;
  always_comb begin
    found = 1'b0;
    sel = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (!found && pending_nz_o[j]) begin
        found = 1'b1;
        sel = IDX_WIDTH'(j);
      end
    end
  end
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic acc, dec;
    assign pending_nz_o[i]  = |pending_q[i];
    assign delta_ready_o[i] = pending_q[i] <= RDY_LIM;
    assign acc = delta_valid_i[i] && delta_ready_o[i];
    assign dec = load && found && (sel == IDX_WIDTH'(i));
    assign pending_d[i] = pending_q[i]
                        + (acc ? CNT_WIDTH'(delta_i[i*DELTA_WIDTH +: DELTA_WIDTH]) : '0)
                        - CNT_WIDTH'(dec);
  end
  always_comb begin
    grant_valid_d  = load ? found : grant_valid_q;
    grant_idx_d    = load ? sel : grant_idx_q;
    grant_onehot_d = load ? (found ? NUM_REQ'(1) << sel : '0) : grant_onehot_q;
    rr_d           = (load && found) ? ((sel == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1) : rr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q      <= '0;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      grant_idx_q    <= '0;
      rr_q           <= '0;
    end else begin
      pending_q      <= pending_d;
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
      grant_idx_q    <= grant_idx_d;
      rr_q           <= rr_d;
    end
  end
  assign gnt_if.valid  = grant_valid_q;
  assign gnt_if.onehot = grant_onehot_q;
  assign gnt_if.idx    = grant_idx_q;
  assign idle_o        = !(|pending_nz_o) && !grant_valid_q;
endmodule
